// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP memory arbiter slice:
//   - state_t   : arbiter FSM states (IDLE, ISSUE, RDATA)
//   - req_id_t  : requester identifier, with REQ_CPU / REQ_LDR constants
//   - DEF_*     : default widths and lock depth used as parameter defaults
//   - other_req : returns the opposite requester (round-robin helper)
// -----------------------------------------------------------------------------
package sap_pkg;

    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_LOCK = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_LDR = 1'b1;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/sap_rr_pick.sv
// -----------------------------------------------------------------------------
// sap_rr_pick
// Combinational winner selection for the two-requester memory arbiter.
//   cpu_req, ldr_req : pending requests
//   last_gnt         : requester that owned the previous transaction
//   lock_hold        : loader keeps ownership on a conflict (lock qualifier)
//   any              : at least one request is pending
//   win              : selected requester (valid when any is high)
// A lone requester always wins; on a conflict the loader wins if lock_hold
// is set, otherwise the requester that did not win last time.
// -----------------------------------------------------------------------------
module sap_rr_pick
    import sap_pkg::*;
(
    input  logic    cpu_req,
    input  logic    ldr_req,
    input  req_id_t last_gnt,
    input  logic    lock_hold,
    output logic    any,
    output req_id_t win
);

    assign any = cpu_req | ldr_req;

    always_comb begin
        // NOTE: win gets a default before any branch so no path leaves it
        // unassigned; without it synthesis would infer a latch.
        win = REQ_CPU;
        if (cpu_req && ldr_req) begin
            win = lock_hold ? REQ_LDR : other_req(last_gnt);
        end else if (ldr_req) begin
            win = REQ_LDR;
        end
    end

endmodule

// File: rtl/sap_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sap_mem_arbiter
// Arbitrates a CPU port and a loader port onto one synchronous RAM (one-cycle
// read latency). One transaction at a time:
//   write : IDLE -> ISSUE -> IDLE
//   read  : IDLE -> ISSUE -> RDATA -> IDLE
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request, held stable until cpu_gnt
//   cpu_gnt, cpu_rvalid      one-cycle grant / read-data strobes
//   cpu_rdata                CPU read data (holds when cpu_rvalid is low)
//   ldr_req/we/lock/addr/wdata, ldr_gnt, ldr_rvalid, ldr_rdata
//                            same for the loader; ldr_lock asks to keep
//                            ownership across consecutive transactions
//   mem_we/addr/wdata        RAM command (valid in ISSUE; addr/wdata hold)
//   mem_rdata                RAM read data, valid the cycle after ISSUE
//   busy                     high in ISSUE and RDATA
// Configuration:
//   SAP_MEM_ARB_LOCK_EN      when defined, ldr_lock lets the loader keep the
//                            RAM for up to MAX_LOCK consecutive conflicts;
//                            when undefined ldr_lock is ignored.
// -----------------------------------------------------------------------------
module sap_mem_arbiter
    import sap_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic              ldr_lock,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    req_id_t           win;        // owner of the transaction in flight
    req_id_t           last_gnt;   // owner of the previous transaction
    logic              cpu_gnt_q;
    logic              ldr_gnt_q;
    logic              cpu_rv_q;
    logic              ldr_rv_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;

    logic              pick_any;
    req_id_t           pick_win;
    logic              lock_hold;

`ifdef SAP_MEM_ARB_LOCK_EN
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);
    logic [LOCK_W-1:0] lock_cnt;

    // The loader keeps the RAM on a conflict only while it already owns it,
    // is asking to, and has not used up its run of locked grants.
    assign lock_hold = (last_gnt == REQ_LDR) && ldr_lock &&
                       (lock_cnt != LOCK_W'(MAX_LOCK));
`else
    logic lock_unused;

    assign lock_hold   = 1'b0;
    assign lock_unused = ldr_lock & (MAX_LOCK > 0);
`endif

    sap_rr_pick u_pick (
        .cpu_req   (cpu_req),
        .ldr_req   (ldr_req),
        .last_gnt  (last_gnt),
        .lock_hold (lock_hold),
        .any       (pick_any),
        .win       (pick_win)
    );

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them sample the values
        // from before the edge; a blocking = would leak same-cycle updates.
        if (rst) begin
            state       <= IDLE;
            win         <= REQ_CPU;
            last_gnt    <= REQ_LDR;
            cpu_gnt_q   <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            cpu_rv_q    <= 1'b0;
            ldr_rv_q    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
`ifdef SAP_MEM_ARB_LOCK_EN
            lock_cnt    <= '0;
`endif
        end else begin
            // Strobes are one-cycle pulses unless re-armed below.
            cpu_gnt_q <= 1'b0;
            ldr_gnt_q <= 1'b0;
            cpu_rv_q  <= 1'b0;
            ldr_rv_q  <= 1'b0;
            mem_we    <= 1'b0;

            // Latch forwarded read data so rdata holds after the strobe.
            if (cpu_rv_q) cpu_rdata_q <= mem_rdata;
            if (ldr_rv_q) ldr_rdata_q <= mem_rdata;

            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= ISSUE;
                        win   <= pick_win;
                        // The RAM command is registered here so it is
                        // presented for exactly the ISSUE cycle; addr/wdata
                        // then hold until the next capture.
                        if (pick_win == REQ_LDR) begin
                            mem_we    <= ldr_we;
                            mem_addr  <= ldr_addr;
                            mem_wdata <= ldr_wdata;
                            ldr_gnt_q <= 1'b1;
                        end else begin
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            cpu_gnt_q <= 1'b1;
                        end
`ifdef SAP_MEM_ARB_LOCK_EN
                        // Count locked loader grants; any CPU win or an
                        // unlocked capture restarts the run.
                        if (pick_win == REQ_LDR && ldr_lock) begin
                            if (lock_cnt != LOCK_W'(MAX_LOCK)) begin
                                lock_cnt <= lock_cnt + LOCK_W'(1);
                            end
                        end else begin
                            lock_cnt <= '0;
                        end
`endif
                    end
                end

                ISSUE: begin
                    last_gnt <= win;
                    // mem_we still shows this transaction's direction.
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        state    <= RDATA;
                        cpu_rv_q <= (win == REQ_CPU);
                        ldr_rv_q <= (win == REQ_LDR);
                    end
                end

                RDATA: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reset is synchronous, so a strobe registered before rst rises would
    // otherwise still show in the reset cycle; qualifying with rst aborts
    // the transaction without emitting a grant or read strobe.
    assign cpu_gnt    = cpu_gnt_q & ~rst;
    assign ldr_gnt    = ldr_gnt_q & ~rst;
    assign cpu_rvalid = cpu_rv_q  & ~rst;
    assign ldr_rvalid = ldr_rv_q  & ~rst;

    // RAM data arrives in RDATA, so it is forwarded in that cycle and the
    // held copy is shown otherwise.
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign ldr_rdata = ldr_rvalid ? mem_rdata : ldr_rdata_q;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sap_mem_arbiter
// Self-checking bench for sap_mem_arbiter. A behavioural synchronous RAM sits
// on the mem_* port; a shadow copy (model) tracks the contents the bench has
// written, and every read pushes its expected requester/data onto a
// scoreboard queue that a negedge monitor pops when an rvalid strobe appears.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_sap_mem_arbiter;
    import sap_pkg::*;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int MAX_LOCK = 8;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
    logic              mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] ram   [16];
    logic [DATA_W-1:0] model [16];
    bit                ram_ready = 1'b0;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   overlap_cnt  = 0;

    always #5 clk = ~clk;

    sap_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_lock   (ldr_lock),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    function automatic logic [DATA_W-1:0] init_val(input int i);
        if (i == 3) return 8'hA5;
        return DATA_W'(i * 29 + 64);
    endfunction

    // Synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Scoreboard monitor for read returns.
    always @(negedge clk) begin
        if (cpu_rvalid || ldr_rvalid) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: rvalid cpu=%0b ldr=%0b with nothing expected",
                         cpu_rvalid, ldr_rvalid);
            end else begin
                mon_e = sb.pop_front();
                if (ldr_rvalid !== mon_e.id ||
                    (ldr_rvalid ? ldr_rdata : cpu_rdata) !== mon_e.data) begin
                    tests_failed++;
                    $display("FAIL sb_read: got id=%0b data=%h, expected id=%0b data=%h",
                             ldr_rvalid, ldr_rvalid ? ldr_rdata : cpu_rdata,
                             mon_e.id, mon_e.data);
                end
            end
        end
    end

    // Grants and read strobes must never overlap between requesters.
    always @(negedge clk) begin
        assert (!(cpu_gnt && ldr_gnt) && !(cpu_rvalid && ldr_rvalid))
        else begin
            overlap_cnt++;
            $display("FAIL overlap: gnt=%b%b rvalid=%b%b at %0t",
                     cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL idle_timeout: busy=%0b, expected 0", busy);
        end
    endtask

    // One complete transaction from a single requester.
    task automatic do_txn(input bit is_ldr, input bit we,
                          input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (is_ldr) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        if (we) model[addr] = wdata;
        else    sb.push_back('{is_ldr, model[addr]});
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_ldr ? ldr_gnt : cpu_gnt) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL gnt_timeout: requester=%0b got no grant", is_ldr);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; ldr_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_we, busy} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: gnt/rv/we/busy=%b, expected 000000",
                     {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_we, busy});
        end
        tests_run++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_mem: addr=%h wdata=%h, expected 0/0", mem_addr, mem_wdata);
        end
        tests_run++;
        if (cpu_rdata !== '0 || ldr_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_rdata: cpu=%h ldr=%h, expected 0/0", cpu_rdata, ldr_rdata);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3; cpu_wdata = '0;
        sb.push_back('{REQ_CPU, model[3]});
        @(negedge clk);
        tests_run++;
        if (cpu_gnt !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_rd_n: gnt=%0b busy=%0b, expected 0/0", cpu_gnt, busy);
        end
        @(negedge clk);
        tests_run++;
        if ({cpu_gnt, ldr_gnt, busy, mem_we} !== 4'b1010 || mem_addr !== 4'h3) begin
            tests_failed++;
            $display("FAIL cpu_rd_n1: gnt=%b%b busy=%0b we=%0b addr=%h, expected 10 1 0 3",
                     cpu_gnt, ldr_gnt, busy, mem_we, mem_addr);
        end
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5 ||
            ldr_rvalid !== 1'b0 || ldr_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL cpu_rd_n2: rv=%0b rdata=%h ldr_rv=%0b ldr_rdata=%h, expected 1 a5 0 00",
                     cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL cpu_rd_hold: busy=%0b rv=%0b rdata=%h, expected 0 0 a5",
                     busy, cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_write_then_read();
        @(posedge clk); #1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'h5C;
        model[15] = 8'h5C;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({ldr_gnt, cpu_gnt, mem_we} !== 3'b101 || mem_addr !== 4'hF || mem_wdata !== 8'h5C) begin
            tests_failed++;
            $display("FAIL ldr_wr_issue: gnt=%b%b we=%0b addr=%h wdata=%h, expected 10 1 f 5c",
                     ldr_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1 ldr_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 4'hF) begin
            tests_failed++;
            $display("FAIL ldr_wr_after: we=%0b busy=%0b addr=%h, expected 0 0 f",
                     mem_we, busy, mem_addr);
        end
        do_txn(1'b0, 1'b0, 4'hF, 8'h00);
        tests_run++;
        if (cpu_rdata !== 8'h5C || ldr_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL wr_rd_hold: cpu_rdata=%h ldr_rdata=%h, expected 5c 00",
                     cpu_rdata, ldr_rdata);
        end
    endtask

    // Both requesters hold write requests; record the grant order.
    task automatic run_conflict(input int n_grants, input bit lock,
                                input bit exp_seq [16], input string name);
        int n = 0;
        do_reset();
        ldr_lock = lock;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h1; cpu_wdata = 8'h11;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h2; ldr_wdata = 8'h22;
        model[1] = 8'h11; model[2] = 8'h22;
        for (int c = 0; c < 120 && n < n_grants; c++) begin
            @(negedge clk);
            if (cpu_gnt || ldr_gnt) begin
                tests_run++;
                if (ldr_gnt !== exp_seq[n] ||
                    mem_addr !== (exp_seq[n] ? 4'h2 : 4'h1)) begin
                    tests_failed++;
                    $display("FAIL %s_grant%0d: ldr_gnt=%0b addr=%h, expected ldr=%0b",
                             name, n, ldr_gnt, mem_addr, exp_seq[n]);
                end
                n++;
            end
        end
        tests_run++;
        if (n != n_grants) begin
            tests_failed++;
            $display("FAIL %s_count: %0d grants, expected %0d", name, n, n_grants);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
        wait_idle();
    endtask

    task automatic test_round_robin();
        bit seq [16];
        for (int i = 0; i < 16; i++) seq[i] = (i % 2 == 1);
        run_conflict(6, 1'b0, seq, "rr");
    endtask

    task automatic test_lock();
        bit seq [16];
`ifdef SAP_MEM_ARB_LOCK_EN
        for (int i = 0; i < 16; i++) seq[i] = (i != MAX_LOCK);
`else
        for (int i = 0; i < 16; i++) seq[i] = (i % 2 == 1);
`endif
        run_conflict(10, 1'b1, seq, "lock");
    endtask

    task automatic test_reset_abort();
        bit got = 1'b0;
        do_reset();
        @(posedge clk); #1;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h5; ldr_wdata = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ldr_gnt) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL abort_gnt: loader read not granted");
        end
        @(posedge clk); #1;          // now in RDATA
        rst = 1'b1; ldr_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ldr_rvalid !== 1'b0 || ldr_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL abort_rvalid: rv=%0b rdata=%h, expected 0 00", ldr_rvalid, ldr_rdata);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || ldr_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: busy=%0b we=%0b gnt=%0b, expected 0 0 0",
                     busy, mem_we, ldr_gnt);
        end
        // Conflict right after reset: the CPU must win first.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h4;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'h6;
        sb.push_back('{REQ_CPU, model[4]});
        sb.push_back('{REQ_LDR, model[6]});
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_first_conflict: gnt=%b%b, expected cpu=1 ldr=0",
                     cpu_gnt, ldr_gnt);
        end
        @(posedge clk); #1 cpu_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ldr_gnt) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL abort_ldr_gnt: loader not granted after CPU");
        end
        @(posedge clk); #1 ldr_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_raw();
        do_txn(1'b0, 1'b1, 4'h7, 8'h99);
        do_txn(1'b1, 1'b0, 4'h7, 8'h00);
        tests_run++;
        if (ldr_rdata !== 8'h99 || cpu_rdata !== init_val(4)) begin
            tests_failed++;
            $display("FAIL raw_ldr: ldr_rdata=%h cpu_rdata=%h, expected 99 %h",
                     ldr_rdata, cpu_rdata, init_val(4));
        end
        do_txn(1'b1, 1'b1, 4'h7, 8'h42);
        do_txn(1'b0, 1'b0, 4'h7, 8'h00);
        tests_run++;
        if (cpu_rdata !== 8'h42 || ldr_rdata !== 8'h99) begin
            tests_failed++;
            $display("FAIL raw_cpu: cpu_rdata=%h ldr_rdata=%h, expected 42 99",
                     cpu_rdata, ldr_rdata);
        end
    endtask

    task automatic test_final();
        tests_run++;
        if (overlap_cnt != 0) begin
            tests_failed++;
            $display("FAIL overlap_total: %0d overlapping cycles, expected 0", overlap_cnt);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d reads never returned, expected 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = init_val(i);
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr = '0; ldr_wdata = '0;

        test_reset();
        test_cpu_read();
        test_write_then_read();
        test_round_robin();
        test_lock();
        test_reset_abort();
        test_raw();
        repeat (3) @(posedge clk);
        test_final();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
